six_one_demux_tdm: RTL and testbench

1:6 demultiplexer, the receive-side counterpart of the 6:1 channel mux. Steers a single input beat stream onto six registered output channels. Two modes:
- Addressed mode: each beat goes to the channel named by Sel.
- TDM scan mode: an internal slot counter distributes beats 0..5 of a frame and releases all six channels together at frame end.
Sits at the far end of the shared serial/TDM link that the 6:1 mux drives.

---
 rtl/six_one_demux_tdm_if.sv | 27 ++
 rtl/six_one_demux_tdm.sv | 95 +++++++++
 tb/tb_six_one_demux_tdm.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/six_one_demux_tdm_if.sv
// rtl/six_one_demux_tdm_if.sv - beat input and channel output bundle for the 1:6 TDM demux
interface six_one_demux_tdm_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]   In;
    logic               In_valid;
    logic               Sof;
    logic               Mode;
    logic [2:0]         Sel;
    logic               Clr_err;
    logic [6*WIDTH-1:0] Out;
    logic [5:0]         Out_valid;
    logic               Frame_done;
    logic [2:0]         Slot;
    logic               Sel_err;
    logic               Frame_err;

    modport slave (
        input  In, In_valid, Sof, Mode, Sel, Clr_err,
        output Out, Out_valid, Frame_done, Slot, Sel_err, Frame_err
    );

    modport master (
        output In, In_valid, Sof, Mode, Sel, Clr_err,
        input  Out, Out_valid, Frame_done, Slot, Sel_err, Frame_err
    );
endinterface

// File: rtl/six_one_demux_tdm.sv
// rtl/six_one_demux_tdm.sv - 1:6 demux with addressed mode and TDM frame-release mode
module six_one_demux_tdm #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    six_one_demux_tdm_if.slave   bus
);
    logic                 mode_q;
    logic [2:0]           slot_q;
    logic [WIDTH-1:0]     shadow [0:4];
    logic [6*WIDTH-1:0]   out_q;
    logic [5:0]           out_valid_q;
    logic                 frame_done_q;
    logic                 sel_err_q;
    logic                 frame_err_q;

    logic                 mode_changed;
    logic [2:0]           slot_base;
    logic [2:0]           eff_slot;

    // Restarting at slot 0 is enough to discard a partial frame: every shadow
    // entry is rewritten before the next release can happen.
    assign mode_changed = (bus.Mode != mode_q);
    assign slot_base    = mode_changed ? 3'd0 : slot_q;
    assign eff_slot     = bus.Sof ? 3'd0 : slot_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q       <= 1'b0;
            slot_q       <= 3'd0;
            out_q        <= '0;
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
            sel_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            for (int n = 0; n < 5; n++) begin
                shadow[n] <= '0;
            end
        end else begin
            mode_q       <= bus.Mode;
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
            slot_q       <= slot_base;

            if (bus.Clr_err) begin
                sel_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            if (bus.In_valid) begin
                if (!bus.Mode) begin
                    slot_q <= 3'd0;
                    if (bus.Sel > 3'd5) begin
                        sel_err_q <= 1'b1;
                    end else begin
                        for (int n = 0; n < 6; n++) begin
                            if (bus.Sel == 3'(n)) begin
                                out_q[n*WIDTH +: WIDTH] <= bus.In;
                                out_valid_q[n]          <= 1'b1;
                            end
                        end
                    end
                end else begin
                    if (bus.Sof && slot_base != 3'd0) begin
                        frame_err_q <= 1'b1;
                    end
                    if (eff_slot == 3'd5) begin
                        for (int n = 0; n < 5; n++) begin
                            out_q[n*WIDTH +: WIDTH] <= shadow[n];
                        end
                        out_q[5*WIDTH +: WIDTH] <= bus.In;
                        out_valid_q             <= '1;
                        frame_done_q            <= 1'b1;
                        slot_q                  <= 3'd0;
                    end else begin
                        for (int n = 0; n < 5; n++) begin
                            if (eff_slot == 3'(n)) begin
                                shadow[n] <= bus.In;
                            end
                        end
                        slot_q <= eff_slot + 3'd1;
                    end
                end
            end
        end
    end

    assign bus.Out        = out_q;
    assign bus.Out_valid  = out_valid_q;
    assign bus.Frame_done = frame_done_q;
    assign bus.Slot       = slot_q;
    assign bus.Sel_err    = sel_err_q;
    assign bus.Frame_err  = frame_err_q;
endmodule

// File: tb/tb_six_one_demux_tdm.sv
// tb/tb_six_one_demux_tdm.sv - scoreboard bench for the 1:6 TDM demux
module tb_six_one_demux_tdm;
    localparam int W = 8;

    typedef struct packed {
        logic [6*W-1:0] out;
        logic [5:0]     vld;
        logic           fd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    exp_t sb [$];
    exp_t mon_e;
    logic [6*W-1:0] exp_out;

    six_one_demux_tdm_if #(.WIDTH(W)) bus ();

    six_one_demux_tdm #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && (bus.Out_valid !== 6'd0 || bus.Frame_done !== 1'b0)) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_strobe out_valid=%b frame_done=%b required none",
                         bus.Out_valid, bus.Frame_done);
            end else begin
                mon_e = sb.pop_front();
                if (bus.Out !== mon_e.out || bus.Out_valid !== mon_e.vld || bus.Frame_done !== mon_e.fd)
                    $display("FAIL scoreboard out=%h vld=%b fd=%b required out=%h vld=%b fd=%b",
                             bus.Out, bus.Out_valid, bus.Frame_done, mon_e.out, mon_e.vld, mon_e.fd);
                else
                    passed++;
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic [2:0] s, input logic m, input logic sof);
        bus.In       = d;
        bus.Sel      = s;
        bus.Mode     = m;
        bus.Sof      = sof;
        bus.In_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.In_valid = 1'b0;
        bus.Sof      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_addr(input int k, input logic [7:0] d);
        exp_out[k*W +: W] = d;
        sb.push_back('{exp_out, 6'(1 << k), 1'b0});
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int i = 0; i < 6; i++) exp_out[i*W +: W] = base + 8'(i);
        sb.push_back('{exp_out, 6'h3F, 1'b1});
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        checks++;
        if (bus.Out !== '0 || bus.Out_valid !== 6'd0 || bus.Frame_done !== 1'b0 ||
            bus.Slot !== 3'd0 || bus.Sel_err !== 1'b0 || bus.Frame_err !== 1'b0)
            $display("FAIL reset_state out=%h vld=%b fd=%b slot=%0d se=%b fe=%b required all zero",
                     bus.Out, bus.Out_valid, bus.Frame_done, bus.Slot, bus.Sel_err, bus.Frame_err);
        else passed++;
        rst_n = 1'b1;
        exp_out = '0;
        idle(1);
    endtask

    task automatic test_addressed;
        push_addr(3, 8'hA5);
        beat(8'hA5, 3'd3, 1'b0, 1'b0);
        checks++;
        if (bus.Out_valid !== 6'b001000) $display("FAIL addr_strobe3 got=%b required=001000", bus.Out_valid);
        else passed++;
        push_addr(0, 8'h3C);
        beat(8'h3C, 3'd0, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (bus.Out !== exp_out || bus.Out_valid !== 6'd0)
            $display("FAIL addr_hold out=%h vld=%b required out=%h vld=000000", bus.Out, bus.Out_valid, exp_out);
        else passed++;
        checks++;
        if (bus.Slot !== 3'd0) $display("FAIL addr_slot got=%0d required=0", bus.Slot);
        else passed++;
    endtask

    task automatic test_sel_err;
        beat(8'hFF, 3'd7, 1'b0, 1'b0);
        checks++;
        if (bus.Sel_err !== 1'b1 || bus.Out !== exp_out)
            $display("FAIL sel_err_set se=%b out=%h required se=1 out=%h", bus.Sel_err, bus.Out, exp_out);
        else passed++;
        idle(2);
        checks++;
        if (bus.Sel_err !== 1'b1) $display("FAIL sel_err_sticky got=%b required=1", bus.Sel_err);
        else passed++;
        bus.Clr_err = 1'b1;
        idle(1);
        bus.Clr_err = 1'b0;
        checks++;
        if (bus.Sel_err !== 1'b0) $display("FAIL sel_err_clear got=%b required=0", bus.Sel_err);
        else passed++;
    endtask

    task automatic test_tdm_frame;
        beat(8'h10, 3'd0, 1'b1, 1'b1);
        checks++;
        if (bus.Slot !== 3'd1) $display("FAIL tdm_slot1 got=%0d required=1", bus.Slot);
        else passed++;
        beat(8'h11, 3'd0, 1'b1, 1'b0);
        beat(8'h12, 3'd0, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (bus.Slot !== 3'd3 || bus.Out !== exp_out)
            $display("FAIL tdm_gap slot=%0d out=%h required slot=3 out=%h", bus.Slot, bus.Out, exp_out);
        else passed++;
        beat(8'h13, 3'd0, 1'b1, 1'b0);
        beat(8'h14, 3'd0, 1'b1, 1'b0);
        checks++;
        if (bus.Slot !== 3'd5 || bus.Out !== exp_out)
            $display("FAIL tdm_partial slot=%0d out=%h required slot=5 out=%h", bus.Slot, bus.Out, exp_out);
        else passed++;
        push_frame(8'h10);
        beat(8'h15, 3'd0, 1'b1, 1'b0);
        checks++;
        if (bus.Slot !== 3'd0 || bus.Frame_done !== 1'b1)
            $display("FAIL tdm_release slot=%0d fd=%b required slot=0 fd=1", bus.Slot, bus.Frame_done);
        else passed++;
        idle(1);
        checks++;
        if (bus.Frame_done !== 1'b0 || bus.Out_valid !== 6'd0 || bus.Out !== exp_out)
            $display("FAIL tdm_after fd=%b vld=%b out=%h required fd=0 vld=0 out=%h",
                     bus.Frame_done, bus.Out_valid, bus.Out, exp_out);
        else passed++;
    endtask

    task automatic test_sof_resync;
        for (int i = 0; i < 3; i++) beat(8'hA0 + 8'(i), 3'd0, 1'b1, 1'b0);
        checks++;
        if (bus.Frame_err !== 1'b0) $display("FAIL resync_pre fe=%b required=0", bus.Frame_err);
        else passed++;
        beat(8'h20, 3'd0, 1'b1, 1'b1);
        checks++;
        if (bus.Frame_err !== 1'b1 || bus.Slot !== 3'd1)
            $display("FAIL resync_err fe=%b slot=%0d required fe=1 slot=1", bus.Frame_err, bus.Slot);
        else passed++;
        for (int i = 1; i < 5; i++) beat(8'h20 + 8'(i), 3'd0, 1'b1, 1'b0);
        checks++;
        if (bus.Out !== exp_out) $display("FAIL resync_hidden out=%h required=%h", bus.Out, exp_out);
        else passed++;
        push_frame(8'h20);
        beat(8'h25, 3'd0, 1'b1, 1'b0);
        bus.Clr_err = 1'b1;
        idle(1);
        bus.Clr_err = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        for (int i = 0; i < 4; i++) beat(8'hB0 + 8'(i), 3'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        exp_out = '0;
        checks++;
        if (bus.Out !== '0 || bus.Slot !== 3'd0 || bus.Out_valid !== 6'd0 || bus.Frame_err !== 1'b0)
            $display("FAIL midreset out=%h slot=%0d vld=%b fe=%b required all zero",
                     bus.Out, bus.Slot, bus.Out_valid, bus.Frame_err);
        else passed++;
        for (int i = 0; i < 5; i++) beat(8'h30 + 8'(i), 3'd0, 1'b1, 1'b0);
        push_frame(8'h30);
        beat(8'h35, 3'd0, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic test_mode_switch;
        beat(8'hC0, 3'd0, 1'b1, 1'b0);
        beat(8'hC1, 3'd0, 1'b1, 1'b0);
        checks++;
        if (bus.Slot !== 3'd2) $display("FAIL switch_pre slot=%0d required=2", bus.Slot);
        else passed++;
        push_addr(5, 8'h77);
        beat(8'h77, 3'd5, 1'b0, 1'b0);
        checks++;
        if (bus.Slot !== 3'd0 || bus.Frame_done !== 1'b0 || bus.Out_valid !== 6'b100000)
            $display("FAIL switch_addr slot=%0d fd=%b vld=%b required slot=0 fd=0 vld=100000",
                     bus.Slot, bus.Frame_done, bus.Out_valid);
        else passed++;
        idle(1);
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 5; i++) beat(8'h40 + 8'(f*16 + i), 3'd7, 1'b1, 1'b0);
            push_frame(8'h40 + 8'(f*16));
            beat(8'h45 + 8'(f*16), 3'd7, 1'b1, 1'b0);
        end
        idle(1);
        checks++;
        if (bus.Sel_err !== 1'b0 || bus.Slot !== 3'd0 || bus.Out !== exp_out)
            $display("FAIL b2b se=%b slot=%0d out=%h required se=0 slot=0 out=%h",
                     bus.Sel_err, bus.Slot, bus.Out, exp_out);
        else passed++;
    endtask

    initial begin
        checks       = 0;
        passed       = 0;
        exp_out      = '0;
        rst_n        = 1'b0;
        bus.In       = '0;
        bus.In_valid = 1'b0;
        bus.Sof      = 1'b0;
        bus.Mode     = 1'b0;
        bus.Sel      = 3'd0;
        bus.Clr_err  = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_addressed;
        test_sel_err;
        test_tdm_frame;
        test_sof_resync;
        test_reset_mid_frame;
        test_mode_switch;
        test_back_to_back;
        idle(2);
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
